operand_sequencer: RTL
======================

// Module: operand_sequencer
// PURPOSE
//  Upstream feeder for the 8x8 operand/address compute core (module_top).
//  Buffers host-pushed operand pairs in a small FIFO and issues them to the
//  core's data_in_0/data_in_1/addr_in/cs inputs, auto-incrementing addr_in per
//  issue. Replaces bench-driven static operands with a paced issue stream.
// PARAMETERS
//  DATA_W      8  operand width (data_in_0/data_in_1)
//  ADDR_W      4  core address width; addr_in wraps at 2**ADDR_W-1 -> 0
//  DEPTH       4  operand FIFO depth (power of 2, >=2)
//  HOLD_CYCLES 1  cycles cs stays high per issued pair (>=1)
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  en           in   1       issue enable; sampled at issue decision edges
//  addr_clr     in   1       request addr_in <= 0 (pulse)
//  in_valid     in   1       host operand pair valid
//  in_ready     out  1       FIFO not full (combinational from count)
//  in_a         in   DATA_W  operand -> data_in_0
//  in_b         in   DATA_W  operand -> data_in_1
//  data_in_0    out  DATA_W  registered operand A to core
//  data_in_1    out  DATA_W  registered operand B to core
//  addr_in      out  ADDR_W  registered core address
//  cs           out  1       registered chip select to core
//  busy         out  1       FSM in ISSUE
//  addr_wrap    out  1       1-cycle pulse when addr_in steps max -> 0
//  issue_cnt    out  16      pairs issued since reset, wraps 0xFFFF -> 0
// BEHAVIOUR
//  - Reset (reset_n=0, any time, async): all outputs 0, FIFO empty, FSM IDLE,
//    hold counter 0; in-flight issue aborted, cs drops immediately.
//  - Push: in_valid&in_ready at edge -> entry written; in_ready=(count!=DEPTH).
//    Push while full is ignored (no overwrite). No bypass: entry poppable from
//    the next edge. Simultaneous push+pop when not full: count unchanged.
//  - FSM states IDLE, ISSUE.
//    IDLE: at edge with en=1 & FIFO non-empty -> pop head, load data_in_0/1,
//      cs<=1, hold<=1, go ISSUE. Push-to-cs latency: 2 edges.
//    ISSUE: hold increments each edge; at edge where hold==HOLD_CYCLES (issue
//      end): addr_in<=addr_in+1 (or 0 if addr_clr pending), issue_cnt++;
//      then if en=1 & FIFO non-empty: pop next, cs stays 1, hold<=1 (back-to-
//      back, no gap); else cs<=0, go IDLE.
//  - addr_in is constant while cs=1; the issued pair uses the addr_in value in
//    effect when it was popped. First issue after reset uses addr 0.
//  - addr_clr: in IDLE takes effect next edge; in ISSUE latched and applied at
//    issue end instead of the increment (no addr_wrap pulse for a clear).
//  - addr_wrap: high for the cycle after addr_in changes 2**ADDR_W-1 -> 0 by
//    increment.
//  - en=0 during ISSUE: current hold completes, then IDLE.
//  - data_in_0/1 retain last issued values when cs=0.
// TESTING
//  1 Reset: reset_n=0 mid-ISSUE -> cs,addr_in,issue_cnt,busy=0 same cycle;
//    in_ready=1.
//  2 Single issue: push (0x13,0x03), en=1 -> 2 edges later cs=1 for 1 cycle,
//    data_in_0=0x13, data_in_1=0x03, addr_in=0; then addr_in=1, issue_cnt=1.
//  3 Back-to-back: push 4 pairs, HOLD_CYCLES=1 -> cs high 4 cycles, no gap,
//    addr_in 0,1,2,3 per cycle; in_ready=0 after 4th push until first pop.
//  4 Wrap: 17 issues -> addr_in 15 then 0 with addr_wrap pulse; 17th uses 0.
//  5 Full/overflow: 5 pushes with en=0 -> 5th ignored; en=1 -> exactly 4
//    issues, issue_cnt=4.
//  6 addr_clr mid-ISSUE (HOLD_CYCLES=3, addr 5): addr_in holds 5 during cs,
//    becomes 0 (not 6) at issue end; no addr_wrap.

Source files
------------

// File: rtl/operand_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : operand_sequencer
// Description : Buffers host-pushed operand pairs in a small FIFO and issues
//               them to the 8x8 compute core as a paced stream: operands on
//               data_in_0/1, chip select held HOLD_CYCLES per pair, and an
//               auto-incrementing core address.
// Revision    : 1.0 - initial release
//==============================================================================
module operand_sequencer #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              addr_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] data_in_0,
    output logic [DATA_W-1:0] data_in_1,
    output logic [ADDR_W-1:0] addr_in,
    output logic              cs,
    output logic              busy,
    output logic              addr_wrap,
    output logic [15:0]       issue_cnt
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ISSUE = 1'b1;

    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;

    // FIFO storage and bookkeeping
    logic [2*DATA_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    // Issue engine
    logic [0:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_clr_pend;
    logic [DATA_W-1:0]   r_data0;
    logic [DATA_W-1:0]   r_data1;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_cs;
    logic                r_wrap;
    logic [15:0]         r_issue_cnt;

    logic                w_not_empty;
    logic                w_push;
    logic                w_end;
    logic                w_pop;
    logic [2*DATA_W-1:0] w_head;

    assign in_ready    = (r_count != c_CNT_W'(DEPTH));
    assign w_not_empty = (r_count != '0);
    assign w_push      = in_valid && in_ready;
    // Issue end is the edge on which the last hold cycle of the current pair completes
    assign w_end       = (r_state == c_ISSUE) && (r_hold == c_HOLD_W'(HOLD_CYCLES));
    // A pop happens either when starting from idle or when chaining back-to-back
    assign w_pop       = en && w_not_empty && ((r_state == c_IDLE) || w_end);
    assign w_head      = r_mem[r_rd_ptr];

    assign data_in_0 = r_data0;
    assign data_in_1 = r_data1;
    assign addr_in   = r_addr;
    assign cs        = r_cs;
    assign busy      = (r_state == c_ISSUE);
    assign addr_wrap = r_wrap;
    assign issue_cnt = r_issue_cnt;

    // FIFO payload write; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count alone
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM: load operands on pop, hold cs, then step the address at issue end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_hold      <= '0;
            r_clr_pend  <= 1'b0;
            r_data0     <= '0;
            r_data1     <= '0;
            r_addr      <= '0;
            r_cs        <= 1'b0;
            r_wrap      <= 1'b0;
            r_issue_cnt <= '0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (addr_clr) begin
                        r_addr <= '0;
                    end
                    if (w_pop) begin
                        r_data0 <= w_head[2*DATA_W-1:DATA_W];
                        r_data1 <= w_head[DATA_W-1:0];
                        r_cs    <= 1'b1;
                        r_hold  <= c_HOLD_W'(1);
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (w_end) begin
                        // A clear requested during the hold replaces the increment
                        if (r_clr_pend || addr_clr) begin
                            r_addr <= '0;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                            if (r_addr == c_ADDR_MAX) begin
                                r_wrap <= 1'b1;
                            end
                        end
                        r_clr_pend  <= 1'b0;
                        r_issue_cnt <= r_issue_cnt + 16'd1;
                        if (w_pop) begin
                            r_data0 <= w_head[2*DATA_W-1:DATA_W];
                            r_data1 <= w_head[DATA_W-1:0];
                            r_hold  <= c_HOLD_W'(1);
                        end else begin
                            r_cs    <= 1'b0;
                            r_hold  <= '0;
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_hold <= r_hold + c_HOLD_W'(1);
                        if (addr_clr) begin
                            r_clr_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cs    <= 1'b0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
